// File: rtl/frame_serializer_pkg.sv
// Shared types and defaults for the frame serializer.
package frame_serializer_pkg;

    typedef enum logic {
        STOP = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int DEF_FRAME_W = 4;
    localparam logic [DEF_FRAME_W-1:0] DEF_FILLER = 4'b1111;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/frame_serializer_hold_buf.sv
// One-entry holding buffer between the word handshake and the frame loader.
module ser_hold_buf #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd,
    output logic         full,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (wr) begin
            full <= 1'b1;
            data <= wr_data;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Gap-free, frame-aligned parallel-to-serial transmitter with filler frames.
// Optional word/filler frame counters under FRAME_SERIALIZER_STATS_EN.
//
// state | meaning
// STOP  | line idle, out_valid low, waiting for tx_en at a boundary
// SEND  | shifting out a frame, cnt = index of bit currently on out_bit
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int                   FRAME_W   = DEF_FRAME_W,
    parameter logic [FRAME_W-1:0]   FILLER    = DEF_FILLER,
    parameter bit                   LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_en,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_bit,
    output logic               out_valid,
    output logic               frame_start,
`ifdef FRAME_SERIALIZER_STATS_EN
    output logic [15:0]        data_frames,
    output logic [15:0]        filler_frames,
`endif
    output logic               out_is_filler
);

    localparam int CNT_W = cnt_width(FRAME_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    state_t             state, state_n;
    logic [FRAME_W-1:0] sr, sr_n, word, buf_data;
    logic [CNT_W-1:0]   cnt, cnt_n, kidx;
    logic               bit_n, valid_n, start_n, filler_n;
    logic               buf_full, buf_wr, buf_rd, hs, at_last, load, take_filler;

    assign in_ready    = !buf_full;
    assign hs          = in_valid && in_ready;
    assign at_last     = (state == SEND) && (cnt == LAST);
    assign load        = tx_en && ((state == STOP) || at_last);
    // A handshake at a load point with an empty buffer goes straight to sr.
    assign buf_wr      = hs && !(load && !buf_full);
    assign buf_rd      = load && buf_full;
    assign take_filler = !buf_full && !hs;
    assign word        = buf_full ? buf_data : (hs ? in_data : FILLER);
    assign kidx        = LSB_FIRST ? (cnt + CNT_W'(1)) : (CNT_W'(FRAME_W - 2) - cnt);

    ser_hold_buf #(.W(FRAME_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (buf_wr),
        .wr_data (in_data),
        .rd      (buf_rd),
        .full    (buf_full),
        .data    (buf_data)
    );

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = cnt;
        bit_n    = 1'b0;
        valid_n  = 1'b0;
        start_n  = 1'b0;
        filler_n = 1'b0;
        if (load) begin
            state_n  = SEND;
            sr_n     = word;
            cnt_n    = '0;
            bit_n    = LSB_FIRST ? word[0] : word[FRAME_W-1];
            valid_n  = 1'b1;
            start_n  = 1'b1;
            filler_n = take_filler;
        end else if (state == SEND && !at_last) begin
            cnt_n    = cnt + CNT_W'(1);
            bit_n    = sr[kidx];
            valid_n  = 1'b1;
            filler_n = out_is_filler;
        end else if (at_last) begin
            state_n = STOP;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= STOP;
            sr            <= '0;
            cnt           <= '0;
            out_bit       <= 1'b0;
            out_valid     <= 1'b0;
            frame_start   <= 1'b0;
            out_is_filler <= 1'b0;
        end else begin
            state         <= state_n;
            sr            <= sr_n;
            cnt           <= cnt_n;
            out_bit       <= bit_n;
            out_valid     <= valid_n;
            frame_start   <= start_n;
            out_is_filler <= filler_n;
        end
    end

`ifdef FRAME_SERIALIZER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_frames   <= '0;
            filler_frames <= '0;
        end else if (load) begin
            if (take_filler) filler_frames <= filler_frames + 16'd1;
            else             data_frames   <= data_frames + 16'd1;
        end
    end
`endif

endmodule
